// File: rtl/issue_select_ctrl_pkg.sv
// Shared constants, types and bit-vector helpers for the issue-slot scheduler.
package issue_pkg;

  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_IDX_W     = $clog2(DEF_NUM_SLOTS);
  // Helpers work on a wide vector so any slot count up to this size can share them.
  localparam int MAX_SLOTS     = 64;

  typedef logic [DEF_IDX_W-1:0]     slot_idx_t;
  typedef logic [DEF_NUM_SLOTS-1:0] slot_vec_t;
  typedef logic [MAX_SLOTS-1:0]     wide_vec_t;

  function automatic wide_vec_t lowest_set(wide_vec_t v);
    return v & (~v + wide_vec_t'(1));
  endfunction

  function automatic int unsigned onehot_to_idx(wide_vec_t v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_SLOTS; i++)
      if (v[i]) idx |= unsigned'(i);
    return idx;
  endfunction

endpackage

// File: rtl/issue_select_ctrl_age.sv
// Age matrix over the issue slots: tracks relative age of occupants and
// picks the oldest requesting slot. age_q[i][j]=1 means slot i is older than j.
module age_matrix_select #(
  parameter int NUM_SLOTS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NUM_SLOTS-1:0] occ,
  input  logic [NUM_SLOTS-1:0] alloc_onehot,
  input  logic [NUM_SLOTS-1:0] grant,
  input  logic [NUM_SLOTS-1:0] req_eff,
  output logic [NUM_SLOTS-1:0] oldest
);

  logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] age_q, age_d;
  logic [NUM_SLOTS-1:0]                blocked;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (flush || i == j)
          age_d[i][j] = 1'b0;
        else if (alloc_onehot[j])
          // new entry j is younger than every occupant that survives this cycle
          age_d[i][j] = occ[i] & ~grant[i];
        else if (alloc_onehot[i] || grant[i] || grant[j])
          age_d[i][j] = 1'b0;
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      for (int j = 0; j < NUM_SLOTS; j++)
        if (j != i && req_eff[j] && age_q[j][i]) blocked[i] = 1'b1;
    oldest = req_eff & ~blocked;
  end

  always_ff @(posedge clk) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end

endmodule

// File: rtl/issue_select_ctrl.sv
// Issue-slot scheduler: allocates free slots to dispatched micro-ops and
// grants the oldest requesting slot to the functional unit each cycle.
module issue_select_ctrl
  import issue_pkg::*;
#(
  parameter  int NUM_SLOTS = DEF_NUM_SLOTS,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  output logic [NUM_SLOTS-1:0] alloc_onehot,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic [NUM_SLOTS-1:0] slot_request,
  input  logic                 fu_ready,
  output logic [NUM_SLOTS-1:0] slot_grant,
  output logic                 issue_valid,
  output logic [IDX_W-1:0]     issue_idx,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [IDX_W:0]       count,
  output logic                 full,
  output logic                 empty
);

  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [IDX_W:0]       count_q, count_d;
  logic [NUM_SLOTS-1:0] req_eff, oldest, free_oh;

  assign req_eff = slot_request & occ_q;

  age_matrix_select #(.NUM_SLOTS(NUM_SLOTS)) u_age (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .occ          (occ_q),
    .alloc_onehot (alloc_onehot),
    .grant        (slot_grant),
    .req_eff      (req_eff),
    .oldest       (oldest)
  );

  always_comb begin
    slot_grant     = (fu_ready && !flush) ? oldest : '0;
    issue_valid    = |slot_grant;
    issue_idx      = IDX_W'(onehot_to_idx(MAX_SLOTS'(slot_grant)));

    // uses registered occupancy, so a slot granted this cycle is not reused until next cycle
    dispatch_ready = !(&occ_q) && !flush;
    free_oh        = NUM_SLOTS'(lowest_set(MAX_SLOTS'(~occ_q)));
    alloc_onehot   = (dispatch_valid && dispatch_ready) ? free_oh : '0;
    alloc_idx      = IDX_W'(onehot_to_idx(MAX_SLOTS'(alloc_onehot)));

    if (flush) begin
      occ_d   = '0;
      count_d = '0;
    end else begin
      occ_d   = (occ_q & ~slot_grant) | alloc_onehot;
      count_d = count_q + (IDX_W+1)'(|alloc_onehot) - (IDX_W+1)'(issue_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      count_q <= count_d;
    end
  end

  assign occupied = occ_q;
  assign count    = count_q;
  assign full     = (count_q == (IDX_W+1)'(NUM_SLOTS));
  assign empty    = (count_q == '0);

endmodule

// File: tb/tb_issue_select_ctrl.sv
// Scoreboard bench for issue_select_ctrl: a queue-of-slots age model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_issue_select_ctrl;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset, flush, dispatch_valid, fu_ready;
  logic          dispatch_ready, issue_valid, full, empty;
  logic [N-1:0]  alloc_onehot, slot_request, slot_grant, occupied;
  logic [IW-1:0] alloc_idx, issue_idx;
  logic [IW:0]   count;

  always #5 clk = ~clk;

  issue_select_ctrl #(.NUM_SLOTS(N)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .alloc_onehot(alloc_onehot), .alloc_idx(alloc_idx),
    .slot_request(slot_request), .fu_ready(fu_ready),
    .slot_grant(slot_grant), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .occupied(occupied), .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic          rdy;
    logic [N-1:0]  aoh;
    logic [IW-1:0] aidx;
    logic [N-1:0]  gnt;
    logic          iv;
    logic [IW-1:0] iidx;
    logic [N-1:0]  occ;
    logic [IW:0]   cnt;
    logic          full;
    logic          empty;
  } exp_t;

  exp_t sb[$];
  int   order[$];   // occupied slots, oldest first
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic bit in_use(int s);
    foreach (order[k]) if (order[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  task automatic step(input logic v, input logic [N-1:0] req, input logic fu,
                      input logic fl, input logic rs);
    exp_t e;
    int   g, a;
    g = -1; a = -1;
    dispatch_valid = v; slot_request = req; fu_ready = fu; flush = fl; reset = rs;
    if (fu && !fl)
      foreach (order[k]) if (g < 0 && req[order[k]]) g = order[k];
    e.rdy = (order.size() < N) && !fl;
    if (v && e.rdy)
      for (int s = 0; s < N; s++) if (a < 0 && !in_use(s)) a = s;
    e.aoh = '0; e.aidx = '0; e.gnt = '0; e.iidx = '0; e.occ = '0;
    if (a >= 0) begin e.aoh[a] = 1'b1; e.aidx = IW'(a); end
    if (g >= 0) begin e.gnt[g] = 1'b1; e.iidx = IW'(g); end
    e.iv = (g >= 0);
    foreach (order[k]) e.occ[order[k]] = 1'b1;
    e.cnt   = (IW+1)'(order.size());
    e.full  = (order.size() == N);
    e.empty = (order.size() == 0);
    sb.push_back(e);
    if (rs || fl) order.delete();
    else begin
      if (g >= 0)
        for (int k = 0; k < order.size(); k++)
          if (order[k] == g) begin order.delete(k); break; end
      if (a >= 0) order.push_back(a);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dispatch_ready", 32'(dispatch_ready), 32'(e.rdy));
      chk("alloc_onehot",   32'(alloc_onehot),   32'(e.aoh));
      chk("alloc_idx",      32'(alloc_idx),      32'(e.aidx));
      chk("slot_grant",     32'(slot_grant),     32'(e.gnt));
      chk("issue_valid",    32'(issue_valid),    32'(e.iv));
      chk("issue_idx",      32'(issue_idx),      32'(e.iidx));
      chk("occupied",       32'(occupied),       32'(e.occ));
      chk("count",          32'(count),          32'(e.cnt));
      chk("full",           32'(full),           32'(e.full));
      chk("empty",          32'(empty),          32'(e.empty));
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; fu_ready = 1'b0;
    slot_request = '0;
    repeat (2) @(posedge clk);
    #1;
    // in-order allocation after reset
    repeat (3) step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    // oldest of the requesting slots wins
    step(1'b0, 8'h06, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h04, 1'b1, 1'b0, 1'b0);
    // grant and allocate in the same cycle
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // fill, free slot 3, reallocate it, then drain in age order
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h08, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    // stalled functional unit
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h0F, 1'b1, 1'b0, 1'b0);
    // flush with work pending, then flush together with reset
    step(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 500; i++)
      step(($urandom % 4) != 0, N'($urandom), ($urandom % 4) != 0,
           ($urandom % 50) == 0, ($urandom % 200) == 0);
    @(negedge clk); #1;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
